// File: rtl/apb_master.sv
// apb_master: APB initiator. Accepts one host command at a time, drives an
// APB SETUP/ACCESS transfer, honours PREADY wait states and returns the result
// through a one-cycle response strobe. A programmable timeout can abort a
// transfer whose slave never asserts PREADY.
//
// Ports
//   CLK, nRST        clock (rising edge) and asynchronous active-low reset
//   cmd_*            host command: valid/ready handshake, write flag, addr, wdata
//   rsp_*            response: one-cycle valid, read data, timeout qualifier
//   P*               APB master-side signals
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value on the last allowed ACCESS cycle: expiry fires when a
  // further PREADY-low cycle would make the count reach TIMEOUT.
  localparam logic [CW-1:0]     LIM = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [DATA_W-1:0] BAD = DATA_W'(32'hbad5bad5);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid, r_rsp_timeout;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_accept, w_done, w_expire;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_done   = (r_state == S_ACCESS) && PREADY;
  // PREADY has priority: expiry only counts when the slave is still stalling.
  assign w_expire = (TIMEOUT != 0) && (r_state == S_ACCESS) && !PREADY && (r_cnt == LIM);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_expire) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; combinational so an async reset drops PSEL/PENABLE at once
  always_comb begin
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (r_state)
      S_IDLE:   cmd_ready = 1'b1;
      S_SETUP:  PSEL = 1'b1;
      S_ACCESS: begin PSEL = 1'b1; PENABLE = 1'b1; end
      default:  cmd_ready = 1'b0;
    endcase
  end

  // Command capture; held through SETUP/ACCESS and kept in IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
    end
  end

  // Wait-state counter: cleared in SETUP, saturating in ACCESS
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                       r_cnt <= '0;
    else if (r_state == S_SETUP)                     r_cnt <= '0;
    else if (r_state == S_ACCESS && !PREADY && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end

  // Response: one-cycle strobe; rdata only changes on read completion or timeout
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_rdata   <= '0;
    end else begin
      r_rsp_valid   <= w_done || w_expire;
      r_rsp_timeout <= w_expire;
      if (w_done && !r_pwrite) r_rsp_rdata <= PRDATA;
      else if (w_expire)       r_rsp_rdata <= BAD;
    end
  end

  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_rdata   = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT = 4) with a tiny register-slave model
// that answers on the second PSEL cycle.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] XOR_BUF_INPUT = 32'h0000_0008;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready, rsp_valid, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  logic          tb_pready;
  logic [DW-1:0] tb_prdata;
  logic          slave_mode;
  logic [DW-1:0] slv_reg;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;

  always #5 CLK = ~CLK;

  assign PREADY = slave_mode ? (PSEL && PENABLE) : tb_pready;
  assign PRDATA = slave_mode ? ((PADDR == XOR_BUF_INPUT) ? slv_reg : '0) : tb_prdata;

  always @(posedge CLK)
    if (slave_mode && PSEL && PENABLE && PWRITE && PADDR == XOR_BUF_INPUT)
      slv_reg <= PWDATA;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rsp_valid === 1'b1) rsp_seen++;
  endtask

  task automatic cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
  endtask

  initial begin
    nRST = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    tb_pready = 1'b0; tb_prdata = '0; slave_mode = 1'b0; slv_reg = '0;

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel",      PSEL, 0);
    chk("rst_penable",   PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr",     PADDR, 0);
    chk("rst_rdata",     rsp_rdata, 0);
    tick(); nRST = 1'b1; tick();

    // Write, zero wait states
    cmd(1'b1, 32'h04, 32'hA5A5A5A5); tb_pready = 1'b1;
    tick();                                   // cycle 1
    cmd_valid = 1'b0;
    chk("w_c1_psel", PSEL, 1);
    chk("w_c1_pen",  PENABLE, 0);
    chk("w_c1_rdy",  cmd_ready, 0);
    chk("w_c1_addr", PADDR, 32'h04);
    chk("w_c1_pwr",  PWRITE, 1);
    chk("w_c1_wd",   PWDATA, 32'hA5A5A5A5);
    tick();                                   // cycle 2
    chk("w_c2_pen",  PENABLE, 1);
    chk("w_c2_rv",   rsp_valid, 0);
    tick();                                   // cycle 3
    chk("w_c3_rv",   rsp_valid, 1);
    chk("w_c3_to",   rsp_timeout, 0);
    chk("w_c3_rdy",  cmd_ready, 1);
    chk("w_c3_psel", PSEL, 0);
    chk("w_c3_rd",   rsp_rdata, 0);           // write leaves rdata alone
    tick();
    chk("w_c4_rv",   rsp_valid, 0);
    chk("w_idle_addr", PADDR, 32'h04);

    // Read with two wait states
    cmd(1'b0, 32'h10, 32'h0); tb_pready = 1'b0; tb_prdata = 32'h12345678;
    tick(); cmd_valid = 1'b0;                 // cycle 1 SETUP
    tick();                                   // cycle 2 ACCESS, wait
    chk("r_c2_addr", PADDR, 32'h10);
    tick();                                   // cycle 3 ACCESS, wait
    chk("r_c3_pen",  PENABLE, 1);
    chk("r_c3_addr", PADDR, 32'h10);
    tick();                                   // cycle 4 ACCESS, ready
    tb_pready = 1'b1;
    chk("r_c4_rv",   rsp_valid, 0);
    chk("r_c4_addr", PADDR, 32'h10);
    tick();                                   // cycle 5
    tb_pready = 1'b0;
    chk("r_c5_rv",   rsp_valid, 1);
    chk("r_c5_rd",   rsp_rdata, 32'h12345678);
    chk("r_c5_to",   rsp_timeout, 0);
    tick();

    // Timeout: PREADY never rises, 4 ACCESS cycles (cycles 2..5)
    cmd(1'b0, 32'h20, 32'h0);
    tick(); cmd_valid = 1'b0;                 // cycle 1
    tick(); tick(); tick(); tick();           // cycle 5, last ACCESS
    chk("to_c5_psel", PSEL, 1);
    chk("to_c5_rv",   rsp_valid, 0);
    tick();                                   // cycle 6
    chk("to_c6_psel", PSEL, 0);
    chk("to_c6_rv",   rsp_valid, 1);
    chk("to_c6_to",   rsp_timeout, 1);
    chk("to_c6_rd",   rsp_rdata, 32'hbad5bad5);
    tick();
    chk("to_c7_rv",   rsp_valid, 0);
    chk("to_c7_to",   rsp_timeout, 0);

    // PREADY on the expiry edge wins
    cmd(1'b0, 32'h24, 32'h0); tb_prdata = 32'hCAFEF00D;
    tick(); cmd_valid = 1'b0;                 // cycle 1
    tick(); tick(); tick(); tick();           // cycle 5
    tb_pready = 1'b1;
    tick();                                   // cycle 6
    tb_pready = 1'b0;
    chk("tr_c6_rv", rsp_valid, 1);
    chk("tr_c6_to", rsp_timeout, 0);
    chk("tr_c6_rd", rsp_rdata, 32'hCAFEF00D);
    tick();

    // Back-to-back with cmd_valid held
    rsp_seen = 0;
    cmd(1'b1, 32'h30, 32'h1111); tb_pready = 1'b1;
    tick();                                   // cycle 1 SETUP #1
    cmd(1'b1, 32'h34, 32'h2222);              // ignored until ready
    tick();                                   // cycle 2 ACCESS #1
    chk("bb_c2_addr", PADDR, 32'h30);
    tick();                                   // cycle 3 rsp #1, accept #2
    chk("bb_c3_rv",  rsp_valid, 1);
    chk("bb_c3_rdy", cmd_ready, 1);
    tick();                                   // cycle 4 SETUP #2
    cmd_valid = 1'b0;
    chk("bb_c4_psel", PSEL, 1);
    chk("bb_c4_pen",  PENABLE, 0);
    chk("bb_c4_addr", PADDR, 32'h34);
    chk("bb_c4_wd",   PWDATA, 32'h2222);
    tick(); tick(); tick(); tick();           // cycles 5..8
    chk("bb_pulses", rsp_seen, 2);
    tb_pready = 1'b0;

    // Asynchronous reset during ACCESS
    rsp_seen = 0;
    cmd(1'b0, 32'h40, 32'h0);
    tick(); cmd_valid = 1'b0;                 // cycle 1
    tick();                                   // cycle 2 ACCESS
    chk("ar_c2_pen", PENABLE, 1);
    #2 nRST = 1'b0;
    #1;
    chk("ar_psel", PSEL, 0);
    chk("ar_pen",  PENABLE, 0);
    chk("ar_rv",   rsp_valid, 0);
    chk("ar_rdy",  cmd_ready, 1);
    tick(); nRST = 1'b1;
    tb_pready = 1'b1;
    tick(); tick(); tick();
    chk("ar_no_rsp", rsp_seen, 0);
    chk("ar_idle",   PSEL, 0);
    tb_pready = 1'b0;

    // Register slave: write then read XOR_BUF_INPUT
    slave_mode = 1'b1;
    cmd(1'b1, XOR_BUF_INPUT, 32'hDEADBEEF);
    tick(); cmd_valid = 1'b0;                 // cycle 1
    tick();                                   // cycle 2
    tick();                                   // cycle 3 rsp
    chk("sl_w_rv", rsp_valid, 1);
    chk("sl_w_to", rsp_timeout, 0);
    cmd(1'b0, XOR_BUF_INPUT, 32'h0);
    tick(); cmd_valid = 1'b0;                 // SETUP
    tick();                                   // ACCESS
    tick();                                   // rsp
    chk("sl_r_rv", rsp_valid, 1);
    chk("sl_r_to", rsp_timeout, 0);
    chk("sl_r_rd", rsp_rdata, 32'hDEADBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that turns single-word command requests from a host-side sequencer or test harness into APB transfers toward POLI register slaves.
- Runs the IDLE, SETUP and ACCESS protocol phases and honours slave wait states through PREADY.
- Returns read data, or a timeout flag, through a one-cycle response strobe.
- Counterpart of the POLI APB slave. It drives PADDR using the same register address map.

Parameters:
ADDR_W, 32, width of PADDR and cmd_addr
DATA_W, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
TIMEOUT, 16, maximum number of ACCESS cycles to wait for PREADY; 0 disables the timeout

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
cmd_valid  input  1  host presents a command
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: transfer finished
rsp_rdata  output  DATA_W  captured PRDATA (reads)
rsp_timeout  output  1  qualifies rsp_valid: transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_W  APB address
PWDATA  output  DATA_W  APB write data
PRDATA  input  DATA_W  APB read data
PREADY  input  1  APB slave ready

Behaviour:
- Reset: all outputs are 0 except cmd_ready, which is 1. State = IDLE, timeout counter = 0.
- Reset is asynchronous. Asserting nRST mid-transfer forces IDLE immediately: PSEL and PENABLE drop and no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1, PSEL = 0, PENABLE = 0.
  - On cmd_valid & cmd_ready at a rising edge: register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- SETUP:
  - PSEL = 1, PENABLE = 0, cmd_ready = 0.
  - Always goes to ACCESS on the next edge. Timeout counter cleared.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA are held stable for the whole of SETUP and ACCESS.
  - If PREADY = 1 at the edge: if PWRITE = 0, register PRDATA into rsp_rdata. Then pulse rsp_valid = 1 with rsp_timeout = 0 in the next cycle, and go to IDLE.
  - If PREADY = 0: increment the counter. When TIMEOUT != 0 and the counter reaches TIMEOUT, go to IDLE and pulse rsp_valid = 1 with rsp_timeout = 1. rsp_rdata is loaded with 32'hbad5bad5 (truncated or zero-extended to DATA_W).
  - PREADY seen on the same edge as counter expiry: PREADY wins, normal completion.
- Latency with zero wait states: accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3. Each wait state adds 1 cycle.
- cmd_ready is high again in the same cycle as rsp_valid, so the next command can be accepted there. Minimum spacing between transfers is 3 cycles; no SETUP-less back-to-back transfers.
- In IDLE, PADDR, PWRITE and PWDATA keep their last values (no toggling). PENABLE is never 1 without PSEL.
- Write completions leave rsp_rdata unchanged.
- cmd_valid while cmd_ready = 0 is ignored; the host must hold it until accepted.
- rsp_valid is exactly one cycle per accepted command; there is no back-pressure on the response.
- Counter width is $clog2(TIMEOUT+1) with a minimum of 1 bit. The counter saturates and never wraps.

Test Plan:
- Write with no wait states: cmd write, addr 0x04, wdata 0xA5A5A5A5 -> cycle 1 PSEL = 1, PENABLE = 0; cycle 2 PENABLE = 1 with PREADY = 1; cycle 3 rsp_valid = 1, rsp_timeout = 0, cmd_ready = 1.
- Read with 2 wait states: PREADY low for 2 ACCESS cycles, then high with PRDATA = 0x12345678 -> rsp_valid in cycle 5, rsp_rdata = 0x12345678, PADDR stable throughout.
- Timeout with TIMEOUT = 4: PREADY held 0 -> after 4 ACCESS cycles PSEL drops, rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0xbad5bad5. Repeat with PREADY rising on the expiry edge -> normal completion.
- Back-to-back: cmd_valid held high with 2 commands -> second accepted in the rsp_valid cycle of the first, next SETUP one cycle later, exactly 2 rsp_valid pulses.
- Reset mid-ACCESS: nRST low in cycle 2 -> PSEL, PENABLE and rsp_valid go 0 asynchronously, cmd_ready = 1, and no response after release.
- Against the POLI APB slave (PREADY on second PSEL cycle): write then read XOR_BUF_INPUT -> read returns the written value, rsp_timeout = 0.
